// File: rtl/fib_seq_pkg.sv
// Shared types and constants for the Fibonacci-series sequencer that drives
// the lab register-file + ALU datapath.
package fib_seq_pkg;

    // Sequencer states; encoding is fixed here so every user agrees on it.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEED0 = 3'd1,
        SEED1 = 3'd2,
        CALC  = 3'd3,
        FIN   = 3'd4
    } state_t;

    // ALU opcode for addition; the only operation this sequencer issues.
    localparam logic [2:0] ALU_ADD = 3'b000;

    // Regfile write-data mux selections.
    localparam logic WSEL_SEED = 1'b0;
    localparam logic WSEL_ALU  = 1'b1;

endpackage : fib_seq_pkg

// File: rtl/fib_seq_ctrl.sv
// Fibonacci-series sequencer. On an accepted start it writes seed0 and seed1
// into r[BASE] and r[BASE+1], then has the ALU add the two previous registers
// and writes each sum into the next register, one write per cycle, until n
// terms exist or the ALU reports signed overflow.
//
// All outputs are registered: the next-state logic also computes the output
// values belonging to the next state, so every output changes exactly on the
// clock edge that enters the corresponding state.
module fib_seq_ctrl
    import fib_seq_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int N_REGS = 32,
    parameter int BASE   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] seed0,
    input  logic [DATA_W-1:0] seed1,
    input  logic [ADDR_W-1:0] count,
    input  logic              alu_ovf,
    output logic [ADDR_W-1:0] rf_raddr_a,
    output logic [ADDR_W-1:0] rf_raddr_b,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic              rf_we,
    output logic              rf_wsel,
    output logic [DATA_W-1:0] seed_data,
    output logic [2:0]        alu_op,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    // Index and length carry one extra bit so BASE+i and N_REGS-BASE never wrap.
    localparam int IDX_W = ADDR_W + 1;
    localparam logic [IDX_W-1:0] MAX_N  = IDX_W'(N_REGS - BASE);
    localparam logic [IDX_W-1:0] BASE_I = IDX_W'(BASE);
    localparam logic [IDX_W-1:0] IDX_0  = IDX_W'(32'd0);
    localparam logic [IDX_W-1:0] IDX_1  = IDX_W'(32'd1);
    localparam logic [IDX_W-1:0] IDX_2  = IDX_W'(32'd2);

    // Internal state and latched request
    state_t            state_r;
    logic [IDX_W-1:0]  i_r;
    logic [IDX_W-1:0]  n_r;
    logic [DATA_W-1:0] seed0_r;
    logic [DATA_W-1:0] seed1_r;
    logic              ovf_r;

    // Next values of the internal state
    state_t            state_nxt_s;
    logic [IDX_W-1:0]  i_nxt_s;
    logic [IDX_W-1:0]  n_nxt_s;
    logic [DATA_W-1:0] seed0_nxt_s;
    logic [DATA_W-1:0] seed1_nxt_s;
    logic              ovf_nxt_s;

    // Next values of the registered outputs
    logic [ADDR_W-1:0] raddr_a_nxt_s;
    logic [ADDR_W-1:0] raddr_b_nxt_s;
    logic [ADDR_W-1:0] waddr_nxt_s;
    logic              we_nxt_s;
    logic              wsel_nxt_s;
    logic [DATA_W-1:0] seed_data_nxt_s;
    logic [2:0]        alu_op_nxt_s;
    logic              busy_nxt_s;
    logic              done_nxt_s;

    // Effective length clipped so the last write lands on r[N_REGS-1]
    logic [IDX_W-1:0]  count_ext_s;
    logic [IDX_W-1:0]  n_clip_s;

    assign count_ext_s = {1'b0, count};
    assign n_clip_s    = (count_ext_s < MAX_N) ? count_ext_s : MAX_N;

    // Next-state logic: sequencing, index advance, seed latching and overflow flag
    always_comb begin
        state_nxt_s = state_r;
        i_nxt_s     = i_r;
        n_nxt_s     = n_r;
        seed0_nxt_s = seed0_r;
        seed1_nxt_s = seed1_r;
        ovf_nxt_s   = ovf_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    seed0_nxt_s = seed0;
                    seed1_nxt_s = seed1;
                    n_nxt_s     = n_clip_s;
                    ovf_nxt_s   = 1'b0;
                    i_nxt_s     = IDX_0;
                    if (n_clip_s == IDX_0) begin
                        state_nxt_s = FIN;
                    end else begin
                        state_nxt_s = SEED0;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEED0: begin
                if (n_r == IDX_1) begin
                    state_nxt_s = FIN;
                end else begin
                    state_nxt_s = SEED1;
                end
            end
            SEED1: begin
                i_nxt_s = IDX_2;
                if (n_r == IDX_2) begin
                    state_nxt_s = FIN;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            CALC: begin
                // The write of an overflowing sum still happens; only the run stops.
                if (alu_ovf) begin
                    ovf_nxt_s   = 1'b1;
                    state_nxt_s = FIN;
                end else if (i_r == (n_r - IDX_1)) begin
                    state_nxt_s = FIN;
                end else begin
                    i_nxt_s     = i_r + IDX_1;
                    state_nxt_s = CALC;
                end
            end
            FIN: begin
                // A start seen here is dropped: the next accept happens in IDLE.
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output decode for the state being entered, so outputs can be registered
    always_comb begin
        raddr_a_nxt_s   = {ADDR_W{1'b0}};
        raddr_b_nxt_s   = {ADDR_W{1'b0}};
        waddr_nxt_s     = {ADDR_W{1'b0}};
        we_nxt_s        = 1'b0;
        wsel_nxt_s      = WSEL_SEED;
        seed_data_nxt_s = {DATA_W{1'b0}};
        alu_op_nxt_s    = ALU_ADD;
        done_nxt_s      = 1'b0;
        case (state_nxt_s)
            SEED0: begin
                we_nxt_s        = 1'b1;
                wsel_nxt_s      = WSEL_SEED;
                waddr_nxt_s     = ADDR_W'(BASE_I);
                seed_data_nxt_s = seed0_nxt_s;
            end
            SEED1: begin
                we_nxt_s        = 1'b1;
                wsel_nxt_s      = WSEL_SEED;
                waddr_nxt_s     = ADDR_W'(BASE_I + IDX_1);
                seed_data_nxt_s = seed1_nxt_s;
            end
            CALC: begin
                raddr_a_nxt_s = ADDR_W'(BASE_I + i_nxt_s - IDX_2);
                raddr_b_nxt_s = ADDR_W'(BASE_I + i_nxt_s - IDX_1);
                waddr_nxt_s   = ADDR_W'(BASE_I + i_nxt_s);
                we_nxt_s      = 1'b1;
                wsel_nxt_s    = WSEL_ALU;
                alu_op_nxt_s  = ALU_ADD;
            end
            FIN: begin
                done_nxt_s = 1'b1;
            end
            default: begin
                done_nxt_s = 1'b0;
            end
        endcase
        if (state_nxt_s != IDLE) begin
            busy_nxt_s = 1'b1;
        end else begin
            busy_nxt_s = 1'b0;
        end
    end

    // State, latched request and registered outputs; reset clears everything at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            i_r        <= IDX_0;
            n_r        <= IDX_0;
            seed0_r    <= {DATA_W{1'b0}};
            seed1_r    <= {DATA_W{1'b0}};
            ovf_r      <= 1'b0;
            rf_raddr_a <= {ADDR_W{1'b0}};
            rf_raddr_b <= {ADDR_W{1'b0}};
            rf_waddr   <= {ADDR_W{1'b0}};
            rf_we      <= 1'b0;
            rf_wsel    <= 1'b0;
            seed_data  <= {DATA_W{1'b0}};
            alu_op     <= 3'b000;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            i_r        <= i_nxt_s;
            n_r        <= n_nxt_s;
            seed0_r    <= seed0_nxt_s;
            seed1_r    <= seed1_nxt_s;
            ovf_r      <= ovf_nxt_s;
            rf_raddr_a <= raddr_a_nxt_s;
            rf_raddr_b <= raddr_b_nxt_s;
            rf_waddr   <= waddr_nxt_s;
            rf_we      <= we_nxt_s;
            rf_wsel    <= wsel_nxt_s;
            seed_data  <= seed_data_nxt_s;
            alu_op     <= alu_op_nxt_s;
            busy       <= busy_nxt_s;
            done       <= done_nxt_s;
        end
    end

    assign ovf = ovf_r;

endmodule : fib_seq_ctrl

// File: tb/tb_fib_seq_ctrl.sv
// Self-checking bench for fib_seq_ctrl: a behavioural regfile and ALU close
// the loop around the sequencer, and a reference model derives the expected
// series, write count, completion cycle and overflow flag from plain arithmetic.
module tb_fib_seq_ctrl;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int N_REGS = 32;
    localparam int BASE   = 1;
    localparam logic [31:0] SENT = 32'h6000_0000;

    logic              clk;
    logic              rst;
    logic              start;
    logic [DATA_W-1:0] seed0;
    logic [DATA_W-1:0] seed1;
    logic [ADDR_W-1:0] count;
    logic              alu_ovf;
    logic [ADDR_W-1:0] rf_raddr_a;
    logic [ADDR_W-1:0] rf_raddr_b;
    logic [ADDR_W-1:0] rf_waddr;
    logic              rf_we;
    logic              rf_wsel;
    logic [DATA_W-1:0] seed_data;
    logic [2:0]        alu_op;
    logic              busy;
    logic              done;
    logic              ovf;

    fib_seq_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .N_REGS (N_REGS),
        .BASE   (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seed0      (seed0),
        .seed1      (seed1),
        .count      (count),
        .alu_ovf    (alu_ovf),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_waddr   (rf_waddr),
        .rf_we      (rf_we),
        .rf_wsel    (rf_wsel),
        .seed_data  (seed_data),
        .alu_op     (alu_op),
        .busy       (busy),
        .done       (done),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural regfile and ALU
    logic [31:0] rf [0:N_REGS-1];
    logic        rf_clear;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_sum;

    assign alu_a   = rf[rf_raddr_a];
    assign alu_b   = rf[rf_raddr_b];
    assign alu_sum = alu_a + alu_b;
    assign alu_ovf = (alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31]);

    always @(posedge clk) begin
        if (rf_clear) begin
            for (int k = 0; k < N_REGS; k++) rf[k] <= SENT + 32'(k);
        end else if (rf_we) begin
            rf[rf_waddr] <= rf_wsel ? alu_sum : seed_data;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected terms, number of writes, overflow outcome
    logic [31:0] exp_t [0:N_REGS-1];
    int          exp_w;
    logic        exp_ovf;

    task automatic model_seq(input logic [31:0] s0, input logic [31:0] s1, input int cnt);
        int n;
        longint s;
        n = (cnt < N_REGS - BASE) ? cnt : N_REGS - BASE;
        exp_w   = 0;
        exp_ovf = 1'b0;
        if (n >= 1) begin exp_t[0] = s0; exp_w = 1; end
        if (n >= 2) begin exp_t[1] = s1; exp_w = 2; end
        for (int k = 2; k < n; k++) begin
            s = longint'($signed(exp_t[k-2])) + longint'($signed(exp_t[k-1]));
            exp_t[k] = s[31:0];
            exp_w = k + 1;
            if (s != longint'($signed(s[31:0]))) begin
                exp_ovf = 1'b1;
                break;
            end
        end
    endtask

    // One sequence, starting at a negedge with the DUT idle; extra_cyc < 0 means no
    // second start, 0 means a second start in the expected FIN cycle.
    task automatic run_seq(input logic [31:0] s0, input logic [31:0] s1,
                           input logic [4:0] cnt, input int extra_cyc, input string nm);
        int cyc;
        int ec;
        int done_cyc;
        int writes;
        int busy_cnt;
        int bad_op;
        logic [31:0] want;
        model_seq(s0, s1, int'(cnt));
        ec = (extra_cyc == 0) ? exp_w + 1 : extra_cyc;
        start = 1'b1; seed0 = s0; seed1 = s1; count = cnt; rf_clear = 1'b1;
        @(negedge clk);
        start = 1'b0; rf_clear = 1'b0;
        seed0 = $urandom; seed1 = $urandom; count = 5'($urandom_range(0, 31));
        check_val({nm, "_ovf_clear"}, 64'(ovf), 64'd0);
        cyc = 1; done_cyc = 0; writes = 0; busy_cnt = 0; bad_op = 0;
        while (done_cyc == 0 && cyc <= 64) begin
            if (busy) busy_cnt++;
            if (rf_we) writes++;
            if (rf_we && rf_wsel && alu_op != 3'b000) bad_op++;
            if (done) begin
                done_cyc = cyc;
                check_val({nm, "_ovf"}, 64'(ovf), 64'(exp_ovf));
            end
            if (cyc == ec) begin
                start = 1'b1; seed0 = $urandom; seed1 = $urandom; count = 5'd20;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        check_val({nm, "_done_cycle"}, 64'(done_cyc), 64'(exp_w + 1));
        check_val({nm, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_w + 1));
        check_val({nm, "_writes"}, 64'(writes), 64'(exp_w));
        check_val({nm, "_alu_op"}, 64'(bad_op), 64'd0);
        check_val({nm, "_idle_after"}, 64'({done, busy, rf_we}), 64'd0);
        check_val({nm, "_ovf_sticky"}, 64'(ovf), 64'(exp_ovf));
        for (int k = 0; k < N_REGS; k++) begin
            if (k >= BASE && k - BASE < exp_w) want = exp_t[k-BASE];
            else want = SENT + 32'(k);
            check_val($sformatf("%s_rf%0d", nm, k), 64'(rf[k]), 64'(want));
        end
    endtask

    initial begin
        int bad;
        logic [31:0] a;
        logic [31:0] b;
        rst = 1'b1; start = 1'b0; seed0 = 32'd0; seed1 = 32'd0; count = 5'd0; rf_clear = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_outputs",
                  64'({rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, rf_wsel, seed_data, alu_op, busy, done, ovf}),
                  64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic series with an ignored start in cycle 3
        run_seq(32'd1, 32'd1, 5'd8, 3, "basic");
        check_val("basic_r8_is_21", 64'(rf[8]), 64'd21);

        // Short lengths and the clip
        run_seq(32'd5, 32'd7, 5'd0, -1, "len0");
        run_seq(32'd9, 32'd3, 5'd1, -1, "len1");
        run_seq(32'd4, 32'd6, 5'd2, -1, "len2");
        run_seq(32'd2, 32'd3, 5'd31, -1, "clip");
        check_val("clip_r31", 64'(rf[31]), 64'(exp_t[30]));

        // Overflow abort with a start in FIN, then a start one cycle after done
        run_seq(32'h7FFF_FFFF, 32'd1, 5'd6, 0, "ovf_abort");
        check_val("ovf_abort_r3", 64'(rf[3]), 64'h8000_0000);
        run_seq(32'd1, 32'd2, 5'd5, -1, "after_ovf");

        // Overflow flag holds while idle
        run_seq(32'h4000_0000, 32'h4000_0000, 5'd10, -1, "ovf2");
        repeat (4) @(negedge clk);
        check_val("ovf2_hold", 64'(ovf), 64'd1);

        // Asynchronous reset in cycle 4 of a count=8 run
        start = 1'b1; seed0 = 32'd1; seed1 = 32'd1; count = 5'd8; rf_clear = 1'b1;
        @(negedge clk);
        start = 1'b0; rf_clear = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("midrst_outputs",
                  64'({rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, rf_wsel, seed_data, alu_op, busy, done, ovf}),
                  64'd0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (rf_we || done || busy) bad++;
        end
        rst = 1'b0;
        check_val("midrst_quiet", 64'(bad), 64'd0);
        check_val("midrst_r3", 64'(rf[3]), 64'd2);
        check_val("midrst_r4_untouched", 64'(rf[4]), 64'(SENT + 32'd4));
        run_seq(32'd3, 32'd4, 5'd8, -1, "post_rst");

        // Randomized runs
        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 1) == 0) begin
                a = 32'($urandom_range(0, 1000));
                b = 32'($urandom_range(0, 1000));
            end else begin
                a = $urandom;
                b = $urandom;
            end
            run_seq(a, b, 5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0) ? 0 : -1,
                    $sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fib_seq_ctrl

// File: doc/fib_seq_ctrl.md
Name: fib_seq_ctrl

Overview:
Multi-cycle sequencer for the lab's register-file + ALU datapath.
- On a start pulse it seeds two registers, then repeatedly has the ALU add the previous two registers and writes the sum back into the next register, filling a Fibonacci-type series.
- Sits inside top, between the test stimulus/start logic and the regfile/ALU pair, and owns every regfile address, write-enable and ALU-op signal.

Parameters:
- ADDR_W, 5: regfile address width.
- DATA_W, 32: datapath width.
- N_REGS, 32: number of registers; must equal 2**ADDR_W or less.
- BASE, 1: first register written. r0 is left untouched.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous reset, active-high.
- start, input, 1: one-cycle request pulse; sampled only in IDLE.
- seed0, input, DATA_W: first term; latched at start.
- seed1, input, DATA_W: second term; latched at start.
- count, input, ADDR_W: number of terms requested; latched at start.
- alu_ovf, input, 1: ALU signed-overflow flag for the current add.
- rf_raddr_a, output, ADDR_W: regfile read port A address (term i-2).
- rf_raddr_b, output, ADDR_W: regfile read port B address (term i-1).
- rf_waddr, output, ADDR_W: regfile write address.
- rf_we, output, 1: regfile write enable.
- rf_wsel, output, 1: write-data mux select; 0 = seed_data, 1 = ALU result.
- seed_data, output, DATA_W: seed value driven to the write mux.
- alu_op, output, 3: ALU opcode; 3'b000 = ADD, always ADD while active.
- busy, output, 1: high whenever state is not IDLE.
- done, output, 1: one-cycle completion pulse.
- ovf, output, 1: sticky; set if a sequence aborted on overflow, cleared on the next accepted start.

Behaviour:
- Reset: rst asynchronously forces state IDLE.
  - All outputs go to 0, including ovf and the internal counters/latches.
  - Reset mid-sequence aborts with no further writes and no done pulse.
- Datapath timing assumed: regfile reads are combinational, writes are synchronous on the clk rising edge, the ALU is combinational.
- Effective length: n = min(count, N_REGS-BASE), computed at start.
- State encoding lives in the package. States:
  - IDLE: start=1 latches seeds, count and n, clears ovf, resets index i=0.
    - n==0 goes to FIN; otherwise goes to SEED0.
    - start=0 stays in IDLE.
  - SEED0: rf_we=1, rf_wsel=0, rf_waddr=BASE, seed_data=seed0.
    - n==1 goes to FIN; otherwise goes to SEED1.
  - SEED1: rf_we=1, rf_wsel=0, rf_waddr=BASE+1, seed_data=seed1, i<=2.
    - n==2 goes to FIN; otherwise goes to CALC.
  - CALC: rf_raddr_a=BASE+i-2, rf_raddr_b=BASE+i-1, rf_waddr=BASE+i, rf_we=1, rf_wsel=1, alu_op=ADD.
    - If alu_ovf=1: the write still happens, ovf<=1, go to FIN.
    - Else if i==n-1: go to FIN.
    - Else: i<=i+1 and stay in CALC.
  - FIN: done=1, rf_we=0, then return to IDLE.
- Latency: exactly one write per cycle. For n>=1, done is high in cycle n+1 after the start edge; for n==0, done is high in cycle 1.
- Outside the states listed above, rf_we=0, rf_wsel=0, seed_data=0, and the addresses are 0.
- start while busy is ignored and not queued. start asserted in the FIN cycle is also ignored.
- Arithmetic: i is held in ADDR_W+1 bits, so BASE+i never wraps past N_REGS-1, because of the clip to n. Sum wrap-around is the ALU's concern; the controller only reacts to alu_ovf.
- alu_ovf is ignored outside CALC.

Decomposition:
- Package fib_seq_pkg holds:
  - state enum IDLE/SEED0/SEED1/CALC/FIN, 3-bit;
  - ALU_ADD = 3'b000;
  - WSEL_SEED = 0, WSEL_ALU = 1.
- Single module, no sub-module required.
- The FSM plus one index counter form one natural block. A separate counter module would be a thin wrapper and is not wanted.

Test Plan:
- Basic series: seed0=1, seed1=1, count=8, BASE=1.
  - r1..r8 = 1,1,2,3,5,8,13,21.
  - done high exactly 9 cycles after the start edge; ovf=0.
  - busy high for 9 cycles.
- Short lengths:
  - count=0: done in cycle 1, no rf_we.
  - count=1: only r1=seed0 written, done in cycle 2.
  - count=2: r1, r2 written, done in cycle 3.
- Clip: count=31 with BASE=1.
  - n=31; last write is to r31, no write to r0 or any wrapped address.
  - done in cycle 32.
- Overflow abort: seed0=32'h7FFFFFFF, seed1=1, count=6, bench ALU raises alu_ovf on the first CALC.
  - Write to r3 still occurs.
  - done in the next cycle; ovf=1 sticky until the next start.
- Start while busy: a second start at cycle 3 of a count=8 run is ignored and the run is unchanged; a start 1 cycle after done is accepted and clears ovf.
- Async reset mid-run: assert rst in cycle 4 of a count=8 run.
  - All outputs 0 immediately, no done pulse.
  - After release, a new start completes normally.
